rx_cpl_host_mem: RTL
====================

Name: rx_cpl_host_mem

Overview:
- Receive-side partner of the host-memory read-request transmitter.
- Accepts Completion-with-Data TLPs from the endpoint TRN RX interface and matches each one to its outstanding read by tag.
- Realigns the 3DW-header payload into qwords and writes them into a per-tag slot of the on-chip chunk buffer.
- Pulses chunk_done when the final completion for a tag has been written.

Parameters:
SLOT_QW_LOG2, 6, log2 of qwords per tag slot (64 qwords = 512 bytes).

Ports:
trn_clk  input  1  endpoint user clock
trn_reset_n  input  1  asynchronous active-low reset
trn_rd  input  64  RX data; DW0 in [63:32]
trn_rrem_n  input  8  8'h00 = both DWs valid; 8'h0F = upper DW only
trn_rsof_n  input  1  start of TLP
trn_reof_n  input  1  end of TLP
trn_rsrc_rdy_n  input  1  beat valid
trn_rsrc_dsc_n  input  1  source discontinue
trn_rdst_rdy_n  output  1  ready, low after reset
buf_wr_addr  output  4+SLOT_QW_LOG2  {tag, qword index}
buf_wr_data  output  64  realigned qword
buf_wr_en  output  1  write strobe
chunk_done  output  1  one-cycle pulse
chunk_done_tag  output  4  tag that completed
cpl_error  output  1  one-cycle pulse on bad completion

Behaviour:
- Reset (trn_reset_n low, asynchronous):
  - trn_rdst_rdy_n=1; buf_wr_en, chunk_done and cpl_error =0; buf_wr_addr, buf_wr_data and chunk_done_tag =0.
  - All 16 per-tag qword counters =0; FSM to IDLE.
  - Reset mid-TLP abandons the TLP; no write and no done pulse.
- Out of reset: trn_rdst_rdy_n=0 constantly; the buffer port has no backpressure.
- A beat is accepted when trn_rsrc_rdy_n=0.
- IDLE: on an accepted beat with trn_rsof_n=0, latch beat 0 fields:
  - fmt_type=[62:56]; length=[41:32]; status=[15:13]; byte_count=[11:0].
  - If fmt_type==7'b10_01010 (CplD), go to HDR1; otherwise go to DROP.
  - If trn_reof_n=0 on the same beat, stay in IDLE.
- HDR1 (next accepted beat): tag=[43:40].
  - If status!=0, or length is odd, or length==0: pulse cpl_error, go to DROP, or to IDLE if eof.
  - Otherwise hold=[31:0] (data DW0) and go to DATA.
- DATA, each accepted beat:
  - Write qword {hold, trn_rd[63:32]} to address {tag, cnt[tag]}, then hold<=trn_rd[31:0] and cnt[tag]<=cnt[tag]+1 (wraps modulo 2^SLOT_QW_LOG2).
  - buf_wr_* is registered: 1-cycle latency from the accepted beat.
- End of TLP in DATA: beat with trn_reof_n=0, expected trn_rrem_n=8'h0F. Go to IDLE.
  - If byte_count == length*4 (last completion for the request): one cycle after the final write, pulse chunk_done with chunk_done_tag=tag and clear cnt[tag] to 0.
  - Otherwise cnt[tag] is retained for the next split completion.
- EOF in DATA with trn_rrem_n=8'h00: protocol violation. Write the qword, pulse cpl_error, no chunk_done.
- DROP: consume beats until trn_reof_n=0, then go to IDLE. No writes.
- Discontinue: trn_rsrc_dsc_n=0 in any state forces IDLE.
  - Writes already issued stand.
  - cnt[tag] is restored to its value at TLP start.
  - cpl_error pulses; no chunk_done.
- Gaps with trn_rsrc_rdy_n=1 between beats: FSM holds, no writes.
- Back-to-back TLPs: sof immediately after eof is accepted with no idle cycle.
- Interleaved completions for different tags are allowed; counters are independent per tag.

Optional Feature:
- Macro RX_CPL_STATS_EN.
- When defined, adds outputs stat_cpl_cnt[31:0] and stat_drop_cnt[31:0].
  - stat_cpl_cnt counts every CplD reaching DATA.
  - stat_drop_cnt counts every TLP ending in DROP, error or discontinue.
  - Both reset to 0 and wrap.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Single CplD, tag 3, length 4, byte_count 16, payload DWs A0..A3 → writes {A0,A1}@{3,0}, {A2,A3}@{3,1}; chunk_done with tag 3 one cycle after the last write.
2. Request of 32 DW, tag 5, split into two CplD of 16 DW (byte_count 128, then 64) → 8 writes at slot indices 0..7, single chunk_done only after the second TLP, cnt[5] back to 0.
3. Interleave tag 1 (8 DW) and tag 2 (8 DW) halves with rsrc_rdy gaps → each tag's qwords at indices 0..3 in its own slot, two chunk_done pulses in TLP completion order.
4. Memory-write TLP (fmt_type 7'b11_00000, 2 DW) between completions → no buf_wr_en, no cpl_error, next CplD processed normally.
5. CplD with status 3'b001 (UR) → cpl_error pulse, no writes, no chunk_done; CplD of 4 DW with trn_rsrc_dsc_n asserted on beat 2 → cpl_error, cnt restored, no chunk_done.
6. Assert trn_reset_n low mid-DATA → all outputs return to reset values immediately, the next TLP after release starts at slot index 0.

Source files
------------

// File: rtl/rx_cpl_host_mem_if.sv
// TRN RX stream from the PCIe endpoint: master is the endpoint core, slave the consumer.
interface rx_cpl_host_mem_if;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic        trn_rdst_rdy_n;

  modport master (
    output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n,
    input  trn_rdst_rdy_n
  );

  modport slave (
    input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n,
    output trn_rdst_rdy_n
  );
endinterface

// File: rtl/rx_cpl_host_mem.sv
// Matches CplD TLPs to outstanding reads by tag, realigns payload into qwords and fills per-tag buffer slots.
// Optional statistics counters are enabled by defining RX_CPL_STATS_EN.
module rx_cpl_host_mem #(
  parameter int unsigned SLOT_QW_LOG2 = 6
) (
  input  logic                      trn_clk,
  input  logic                      trn_reset_n,
  rx_cpl_host_mem_if.slave          rx,
  output logic [4+SLOT_QW_LOG2-1:0] buf_wr_addr,
  output logic [63:0]               buf_wr_data,
  output logic                      buf_wr_en,
  output logic                      chunk_done,
  output logic [3:0]                chunk_done_tag,
  output logic                      cpl_error
`ifdef RX_CPL_STATS_EN
  ,
  output logic [31:0]               stat_cpl_cnt,
  output logic [31:0]               stat_drop_cnt
`endif
);

  localparam int unsigned NUM_TAGS = 16;
  localparam int unsigned CNT_W    = SLOT_QW_LOG2;
  localparam logic [6:0]  FMT_CPLD = 7'b10_01010;

  typedef enum logic [1:0] {IDLE, HDR1, DATA, DROP} state_t;

  state_t             state;
  logic [9:0]         length_q;
  logic [2:0]         status_q;
  logic [11:0]        bc_q;
  logic [3:0]         tag_q;
  logic [31:0]        hold_q;
  logic [CNT_W-1:0]   cnt_q [NUM_TAGS];
  logic [CNT_W-1:0]   cnt_start_q;
  logic               done_pend_q;

  logic               beat_c;
  logic               sof_c;
  logic               eof_c;
  logic               dsc_c;
  logic [3:0]         hdr_tag_c;
  logic               hdr_bad_c;
  logic               last_cpl_c;

  // Beat qualifiers and header decode helpers
  always_comb begin
    beat_c     = ~rx.trn_rsrc_rdy_n;
    sof_c      = beat_c & ~rx.trn_rsof_n;
    eof_c      = beat_c & ~rx.trn_reof_n;
    dsc_c      = ~rx.trn_rsrc_dsc_n;
    hdr_tag_c  = rx.trn_rd[43:40];
    hdr_bad_c  = (status_q != 3'd0) | length_q[0] | (length_q == 10'd0);
    last_cpl_c = (bc_q == {length_q, 2'b00});
  end

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state              <= IDLE;
      rx.trn_rdst_rdy_n  <= 1'b1;
      buf_wr_addr        <= '0;
      buf_wr_data        <= '0;
      buf_wr_en          <= 1'b0;
      chunk_done         <= 1'b0;
      chunk_done_tag     <= '0;
      cpl_error          <= 1'b0;
      length_q           <= '0;
      status_q           <= '0;
      bc_q               <= '0;
      tag_q              <= '0;
      hold_q             <= '0;
      cnt_start_q        <= '0;
      done_pend_q        <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) cnt_q[i] <= '0;
`ifdef RX_CPL_STATS_EN
      stat_cpl_cnt       <= '0;
      stat_drop_cnt      <= '0;
`endif
    end else begin
      rx.trn_rdst_rdy_n <= 1'b0;
      buf_wr_en         <= 1'b0;
      cpl_error         <= 1'b0;
      done_pend_q       <= 1'b0;
      chunk_done        <= done_pend_q;
      // tag_q is stable until the next TLP's HDR1 beat, two beats away at the earliest
      if (done_pend_q) chunk_done_tag <= tag_q;

      if (dsc_c) begin
        // Abandon the TLP; undo any slot progress it made
        if (state == DATA) cnt_q[tag_q] <= cnt_start_q;
        if (state != IDLE || sof_c) cpl_error <= 1'b1;
`ifdef RX_CPL_STATS_EN
        if ((state != IDLE && state != DROP) || sof_c) stat_drop_cnt <= stat_drop_cnt + 32'd1;
`endif
        state <= IDLE;
      end else if (beat_c) begin
        case (state)
          IDLE: begin
            if (sof_c) begin
              length_q <= rx.trn_rd[41:32];
              status_q <= rx.trn_rd[15:13];
              bc_q     <= rx.trn_rd[11:0];
              if (!eof_c) state <= (rx.trn_rd[62:56] == FMT_CPLD) ? HDR1 : DROP;
`ifdef RX_CPL_STATS_EN
              if (rx.trn_rd[62:56] != FMT_CPLD) stat_drop_cnt <= stat_drop_cnt + 32'd1;
`endif
            end
          end
          HDR1: begin
            tag_q <= hdr_tag_c;
            if (hdr_bad_c || eof_c) begin
              cpl_error <= 1'b1;
              state     <= eof_c ? IDLE : DROP;
`ifdef RX_CPL_STATS_EN
              stat_drop_cnt <= stat_drop_cnt + 32'd1;
`endif
            end else begin
              hold_q      <= rx.trn_rd[31:0];
              cnt_start_q <= cnt_q[hdr_tag_c];
              state       <= DATA;
`ifdef RX_CPL_STATS_EN
              stat_cpl_cnt <= stat_cpl_cnt + 32'd1;
`endif
            end
          end
          DATA: begin
            buf_wr_en     <= 1'b1;
            buf_wr_addr   <= {tag_q, cnt_q[tag_q]};
            buf_wr_data   <= {hold_q, rx.trn_rd[63:32]};
            hold_q        <= rx.trn_rd[31:0];
            cnt_q[tag_q]  <= CNT_W'(cnt_q[tag_q] + CNT_W'(1));
            if (eof_c) begin
              state <= IDLE;
              if (rx.trn_rrem_n == 8'h00) begin
                // Payload ended on an even DW boundary: not a valid 3DW-header CplD
                cpl_error <= 1'b1;
`ifdef RX_CPL_STATS_EN
                stat_drop_cnt <= stat_drop_cnt + 32'd1;
`endif
              end else if (last_cpl_c) begin
                done_pend_q  <= 1'b1;
                cnt_q[tag_q] <= '0;
              end
            end
          end
          DROP: begin
            if (eof_c) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
